// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: read, issue, writeback and kill bus between the pipeline and the register file
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     kill_en;
  logic [ADDR_W-1:0]        kill_addr;
  logic                     pending_any;
  logic                     sb_err;
  modport master (
    output rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data, kill_en, kill_addr,
    input  rd_data, rd_busy, iss_ready, pending_any, sb_err
  );
  modport slave (
    input  rd_addr, iss_en, iss_addr, wb_en, wb_addr, wb_data, kill_en, kill_addr,
    output rd_data, rd_busy, iss_ready, pending_any, sb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with per-register pending-write counters; REGFILE_BYPASS_EN enables writeback bypass
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2
) (
  input logic clk,
  input logic rst,
  regfile_scoreboard_if.slave bus
);
  localparam int N = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [DATA_W-1:0] regs [N];
  logic [CNT_W-1:0] cnt [N];
  logic [CNT_W-1:0] cnt_nxt [N];
  logic [1:0] dec [N];
  logic [N-1:0] under, nz;
  logic sb_err_q, wr;
  assign wr = bus.wb_en & (bus.wb_addr != '0);
  assign bus.iss_ready = (bus.iss_addr == '0) | (cnt[bus.iss_addr] != CNT_MAX);
  assign bus.pending_any = |nz;
  assign bus.sb_err = sb_err_q;
  for (genvar r = 0; r < N; r++) begin : g_cnt
    logic inc;
    logic [CNT_W:0] up;
    assign inc = (r != 0) & bus.iss_en & bus.iss_ready & (bus.iss_addr == ADDR_W'(r));
    assign dec[r] = (r == 0) ? 2'd0 :
      2'(bus.wb_en & (bus.wb_addr == ADDR_W'(r))) + 2'(bus.kill_en & (bus.kill_addr == ADDR_W'(r)));
    assign up = {1'b0, cnt[r]} + (CNT_W+1)'(inc);
    assign under[r] = up < (CNT_W+1)'(dec[r]);
    assign cnt_nxt[r] = under[r] ? '0 : CNT_W'(up - (CNT_W+1)'(dec[r]));
    assign nz[r] = |cnt[r];
  end
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = bus.rd_addr[i*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign bus.rd_data[i*DATA_W +: DATA_W] = (wr && bus.wb_addr == a) ? bus.wb_data : regs[a];
    assign bus.rd_busy[i] = (CNT_W+1)'(cnt[a]) > (CNT_W+1)'(dec[a]);
`else
    assign bus.rd_data[i*DATA_W +: DATA_W] = regs[a];
    assign bus.rd_busy[i] = |cnt[a];
`endif
  end
  // storage, counters and sticky error; register 0 is never written so it always reads 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < N; r++) begin
        regs[r] <= '0;
        cnt[r] <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < N; r++) cnt[r] <= cnt_nxt[r];
      if (wr) regs[bus.wb_addr] <= bus.wb_data;
      sb_err_q <= sb_err_q | (|under) | (bus.iss_en & ~bus.iss_ready);
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed checks of reads, scoreboard counting, saturation, underflow and reset
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst;
  int errs = 0;
  int checks = 0;
  logic [4:0] av [4] = '{5'd0, 5'd5, 5'd17, 5'd31};
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  always #5 clk = ~clk;
  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();
  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    bus.iss_en = 1'b0; bus.iss_addr = '0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.kill_en = 1'b0; bus.kill_addr = '0;
  endtask
  task automatic do_reset;
    idle;
    rst = 1'b1;
    step;
    rst = 1'b0;
  endtask
  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.rd_addr = {a1, a0};
    #1;
  endtask
  initial begin
    rst = 1'b1;
    idle;
    bus.rd_addr = '0;
    step;
    step;
    rst = 1'b0;
    // reset state at several addresses
    for (int k = 0; k < 4; k++) begin
      bus.iss_addr = av[k];
      rd(av[k], 5'd31 - av[k]);
      chk("rst d0", bus.rd_data[31:0], 32'h0);
      chk("rst d1", bus.rd_data[63:32], 32'h0);
      chk("rst busy", 32'(bus.rd_busy), 32'h0);
      chk("rst ready", 32'(bus.iss_ready), 32'h1);
      chk("rst pend", 32'(bus.pending_any), 32'h0);
      chk("rst err", 32'(bus.sb_err), 32'h0);
    end
    idle;
    // issue r5, writeback three cycles later
    rd(5'd5, 5'd5);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd5;
    #1;
    chk("t2 ready", 32'(bus.iss_ready), 32'h1);
    chk("t2 busy0", 32'(bus.rd_busy), 32'h0);
    step;
    idle;
    #1;
    chk("t2 busy1", 32'(bus.rd_busy), 32'h3);
    chk("t2 pend1", 32'(bus.pending_any), 32'h1);
    step;
    step;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
    #1;
    chk("t2 wb data", bus.rd_data[31:0], BYP ? 32'hDEADBEEF : 32'h0);
    chk("t2 wb busy", 32'(bus.rd_busy), BYP ? 32'h0 : 32'h3);
    step;
    idle;
    #1;
    chk("t2 after d0", bus.rd_data[31:0], 32'hDEADBEEF);
    chk("t2 after d1", bus.rd_data[63:32], 32'hDEADBEEF);
    chk("t2 after busy", 32'(bus.rd_busy), 32'h0);
    chk("t2 after pend", 32'(bus.pending_any), 32'h0);
    chk("t2 after err", 32'(bus.sb_err), 32'h0);
    // saturate r7, overflow issue, drain
    rd(5'd7, 5'd0);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3 ready pre", 32'(bus.iss_ready), 32'h1);
      step;
    end
    #1;
    chk("t3 ready sat", 32'(bus.iss_ready), 32'h0);
    chk("t3 err pre", 32'(bus.sb_err), 32'h0);
    step;
    bus.iss_en = 1'b0;
    #1;
    chk("t3 err ovf", 32'(bus.sb_err), 32'h1);
    chk("t3 busy sat", 32'(bus.rd_busy[0]), 32'h1);
    chk("t3 ready kept", 32'(bus.iss_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      bus.wb_en = 1'b1; bus.wb_addr = 5'd7; bus.wb_data = 32'(k + 1);
      step;
      bus.wb_en = 1'b0;
      #1;
      chk("t3 drain busy", 32'(bus.rd_busy[0]), 32'(k < 2));
      chk("t3 drain ready", 32'(bus.iss_ready), 32'h1);
    end
    chk("t3 data", bus.rd_data[31:0], 32'h3);
    chk("t3 pend", 32'(bus.pending_any), 32'h0);
    // simultaneous issue, writeback and kill of r9, then underflow by kill
    do_reset;
    rd(5'd9, 5'd0);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    step;
    step;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h99;
    bus.kill_en = 1'b1; bus.kill_addr = 5'd9;
    #1;
    chk("t4 ready", 32'(bus.iss_ready), 32'h1);
    chk("t4 busy same", 32'(bus.rd_busy[0]), BYP ? 32'h0 : 32'h1);
    step;
    idle;
    #1;
    chk("t4 busy net", 32'(bus.rd_busy[0]), 32'h1);
    chk("t4 err net", 32'(bus.sb_err), 32'h0);
    chk("t4 data", bus.rd_data[31:0], 32'h99);
    chk("t4 pend", 32'(bus.pending_any), 32'h1);
    bus.kill_en = 1'b1; bus.kill_addr = 5'd9;
    step;
    idle;
    #1;
    chk("t4 kill1 busy", 32'(bus.rd_busy[0]), 32'h0);
    chk("t4 kill1 err", 32'(bus.sb_err), 32'h0);
    chk("t4 kill1 pend", 32'(bus.pending_any), 32'h0);
    bus.kill_en = 1'b1; bus.kill_addr = 5'd9;
    step;
    idle;
    #1;
    chk("t4 kill2 err", 32'(bus.sb_err), 32'h1);
    chk("t4 kill2 busy", 32'(bus.rd_busy[0]), 32'h0);
    chk("t4 kill2 pend", 32'(bus.pending_any), 32'h0);
    // register 0 is neither written nor counted
    do_reset;
    rd(5'd0, 5'd0);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd0; bus.wb_data = 32'h12345678;
    bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
    #1;
    chk("t5 ready", 32'(bus.iss_ready), 32'h1);
    chk("t5 d0 same", bus.rd_data[31:0], 32'h0);
    chk("t5 busy same", 32'(bus.rd_busy), 32'h0);
    step;
    idle;
    #1;
    chk("t5 d0", bus.rd_data[31:0], 32'h0);
    chk("t5 d1", bus.rd_data[63:32], 32'h0);
    chk("t5 busy", 32'(bus.rd_busy), 32'h0);
    chk("t5 pend", 32'(bus.pending_any), 32'h0);
    chk("t5 err", 32'(bus.sb_err), 32'h0);
    // reset drops outstanding counts; a later writeback underflows
    do_reset;
    rd(5'd3, 5'd4);
    bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
    step;
    bus.iss_addr = 5'd4;
    step;
    idle;
    #1;
    chk("t6 busy pre", 32'(bus.rd_busy), 32'h3);
    chk("t6 pend pre", 32'(bus.pending_any), 32'h1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    #1;
    chk("t6 pend rst", 32'(bus.pending_any), 32'h0);
    chk("t6 busy rst", 32'(bus.rd_busy), 32'h0);
    chk("t6 err rst", 32'(bus.sb_err), 32'h0);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'hCAFE0003;
    step;
    idle;
    #1;
    chk("t6 err wb", 32'(bus.sb_err), 32'h1);
    chk("t6 data", bus.rd_data[31:0], 32'hCAFE0003);
    chk("t6 busy wb", 32'(bus.rd_busy), 32'h0);
    chk("t6 pend wb", 32'(bus.pending_any), 32'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
